// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among four level-held message sources.
// Optional periodic resend of live state is compiled in with `UART_ARB_REFRESH_EN.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES     = 16,
  parameter int REFRESH_CYCLES = 6_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_game_state_sel,
  input  logic [7:0] data_shoot_control,
  input  logic [7:0] data_mouse_control,
  input  logic [7:0] data_score_control,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic [1:0] grant_id
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t     state;
  logic [7:0] src_dat   [4];
  logic [7:0] last_sent [4];
  logic [3:0] pending;
  logic [3:0] elig;
  logic [1:0] rr_ptr;
  logic [1:0] winner;
  logic       any_elig;
  logic [7:0] gap_cnt;
  logic       refresh_tick;

  assign src_dat[0] = data_game_state_sel;
  assign src_dat[1] = data_shoot_control;
  assign src_dat[2] = data_mouse_control;
  assign src_dat[3] = data_score_control;

`ifdef UART_ARB_REFRESH_EN
  logic [31:0] refresh_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
    end else if (refresh_tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 32'd1;
    end
  end

  assign refresh_tick = (refresh_cnt == 32'(REFRESH_CYCLES - 1));
`else
  // Period is only meaningful when the resend counter is built.
  localparam int unused_refresh_cycles = REFRESH_CYCLES;
  assign refresh_tick = 1'b0;
`endif

  // A pending source whose word has since dropped to idle must not be granted.
  always_comb begin
    winner   = rr_ptr;
    any_elig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = pending[i] && (src_dat[i] != 8'h00);
    end
    for (int k = 0; k < 4; k++) begin
      if (!any_elig && elig[rr_ptr + 2'(k)]) begin
        winner   = rr_ptr + 2'(k);
        any_elig = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      w_data   <= 8'h00;
      wr_uart  <= 1'b0;
      grant_id <= 2'd0;
      rr_ptr   <= 2'd0;
      gap_cnt  <= 8'd0;
      pending  <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        last_sent[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (src_dat[i] == 8'h00) begin
          last_sent[i] <= 8'h00;
          pending[i]   <= 1'b0;
        end else if ((src_dat[i] != last_sent[i]) ||
                     (refresh_tick && (last_sent[i] != 8'h00))) begin
          pending[i] <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (any_elig && !tx_full) begin
            w_data   <= src_dat[winner];
            grant_id <= winner;
            wr_uart  <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          // Committing the sent word lets a change during SEND re-arm pending next cycle.
          wr_uart             <= 1'b0;
          last_sent[grant_id] <= w_data;
          pending[grant_id]   <= 1'b0;
          rr_ptr              <= grant_id + 2'd1;
          gap_cnt             <= 8'd0;
          state               <= GAP;
        end
        GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with GAP_CYCLES=4 and REFRESH_CYCLES=200.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
  logic       tx_full = 1'b0;
  logic [7:0] w_data;
  logic       wr_uart;
  logic [1:0] grant_id;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.GAP_CYCLES(4), .REFRESH_CYCLES(200)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_game_state_sel (d0),
    .data_shoot_control  (d1),
    .data_mouse_control  (d2),
    .data_score_control  (d3),
    .tx_full             (tx_full),
    .w_data              (w_data),
    .wr_uart             (wr_uart),
    .grant_id            (grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
    tx_full = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  // Advances until a strobe is seen or the budget runs out; returns ticks taken.
  task automatic wait_strobe(input int budget, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      n++;
      seen = wr_uart;
    end
  endtask

  task automatic test_reset();
    int strobes;
    bit bad_out;
    do_reset();
    strobes = 0;
    bad_out = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (wr_uart) strobes++;
      if (w_data !== 8'h00 || grant_id !== 2'd0) bad_out = 1'b1;
    end
    checks++;
    if (strobes != 0) begin
      failures++;
      $display("FAIL reset_no_strobe: got %0d strobes, expected 0", strobes);
    end
    checks++;
    if (bad_out || w_data !== 8'h00 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: w_data=%h grant_id=%0d, expected 00/0", w_data, grant_id);
    end
  endtask

  task automatic test_single();
    int n;
    bit seen;
    d2 = 8'h35;
    tick();
    checks++;
    if (wr_uart !== 1'b0) begin
      failures++;
      $display("FAIL single_early: wr_uart=%b at k+1, expected 0", wr_uart);
    end
    tick();
    checks++;
    if (wr_uart !== 1'b1 || w_data !== 8'h35 || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL single_write: wr=%b data=%h gid=%0d, expected 1/35/2", wr_uart, w_data, grant_id);
    end
    tick();
    checks++;
    if (wr_uart !== 1'b0 || w_data !== 8'h35) begin
      failures++;
      $display("FAIL single_pulse: wr=%b data=%h, expected 0/35", wr_uart, w_data);
    end
    wait_strobe(100, n, seen);
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL single_repeat: strobe after %0d cycles, expected none", n);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_dat [4];
    int n;
    bit seen;
    exp_dat[0] = 8'h11; exp_dat[1] = 8'h22; exp_dat[2] = 8'h33; exp_dat[3] = 8'h44;
    do_reset();
    d0 = 8'h11; d1 = 8'h22; d2 = 8'h33; d3 = 8'h44;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(50, n, seen);
      checks++;
      if (!seen || n != (i == 0 ? 2 : 6) || w_data !== exp_dat[i] || grant_id !== 2'(i)) begin
        failures++;
        $display("FAIL rr_write%0d: seen=%b gap=%0d data=%h gid=%0d, expected gap %0d data %h gid %0d",
                 i, seen, n, w_data, grant_id, (i == 0 ? 2 : 6), exp_dat[i], i);
      end
    end
    d0 = 8'h19;
    wait_strobe(50, n, seen);
    checks++;
    if (!seen || w_data !== 8'h19 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL rr_update: seen=%b data=%h gid=%0d, expected 19 from 0", seen, w_data, grant_id);
    end
  endtask

  task automatic test_tx_full();
    int strobes;
    int n;
    bit seen;
    repeat (30) tick();
    tx_full = 1'b1;
    d3 = 8'h0C;
    strobes = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (wr_uart) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      failures++;
      $display("FAIL full_block: %0d strobes while full, expected 0", strobes);
    end
    tx_full = 1'b0;
    tick();
    checks++;
    if (wr_uart !== 1'b1 || w_data !== 8'h0C || grant_id !== 2'd3) begin
      failures++;
      $display("FAIL full_release: wr=%b data=%h gid=%0d, expected 1/0C/3", wr_uart, w_data, grant_id);
    end
    repeat (30) tick();
    tx_full = 1'b1;
    d3 = 8'h5C;
    repeat (10) tick();
    d3 = 8'h0D;
    repeat (10) tick();
    tx_full = 1'b0;
    tick();
    checks++;
    if (wr_uart !== 1'b1 || w_data !== 8'h0D) begin
      failures++;
      $display("FAIL full_latest: wr=%b data=%h, expected 1/0D", wr_uart, w_data);
    end
    wait_strobe(60, n, seen);
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL full_no_stale: extra write data=%h, expected none", w_data);
    end
  endtask

  task automatic test_reset_mid_send();
    int n;
    bit seen;
    repeat (30) tick();
    d1 = 8'h77;
    tick();
    tick();
    checks++;
    if (wr_uart !== 1'b1) begin
      failures++;
      $display("FAIL midsend_setup: wr=%b, expected 1", wr_uart);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (wr_uart !== 1'b0 || w_data !== 8'h00 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL midsend_async: wr=%b data=%h gid=%0d, expected 0/00/0", wr_uart, w_data, grant_id);
    end
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    wait_strobe(40, n, seen);
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midsend_quiet: strobe after release, expected none");
    end
    d1 = 8'h2A;
    wait_strobe(10, n, seen);
    checks++;
    if (!seen || n != 2 || w_data !== 8'h2A || grant_id !== 2'd1) begin
      failures++;
      $display("FAIL midsend_resume: seen=%b lat=%0d data=%h gid=%0d, expected 2/2A/1", seen, n, w_data, grant_id);
    end
  endtask

  task automatic test_refresh();
    int strobes;
    bit bad;
    strobes = 0;
    bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (wr_uart) begin
        strobes++;
        if (w_data !== 8'h2A || grant_id !== 2'd1) bad = 1'b1;
      end
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL refresh_content: a resend was not 2A from source 1");
    end
`ifdef UART_ARB_REFRESH_EN
    checks++;
    if (strobes < 2 || strobes > 3) begin
      failures++;
      $display("FAIL refresh_count: %0d resends in 500 cycles, expected 2..3", strobes);
    end
`else
    checks++;
    if (strobes != 0) begin
      failures++;
      $display("FAIL refresh_absent: %0d resends, expected 0", strobes);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_tx_full();
    test_reset_mid_send();
    test_refresh();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO write port between the four game blocks that produce link messages: game-state select, shoot control, mouse control and score control. Each source presents an 8-bit message word as a level, with the opcode in bits [2:0]. The arbiter detects new words, queues them, and grants them round-robin. It writes one byte per grant into the UART with a one-cycle `wr_uart` pulse, honouring `tx_full`. It sits between those four controllers and `uart` (TX side) and replaces ad-hoc muxing in the top level.

## Interface
Parameters:
- `GAP_CYCLES`, default 16: idle cycles enforced after every write, 1..255.
- `REFRESH_CYCLES`, default 6_500_000: refresh period in clk cycles (100 ms at 65 MHz); only used when refresh is compiled in.

Ports:
- `clk` in 1: system clock, the single clock of the block.
- `rst` in 1: reset, asynchronous, active-high.
- `data_game_state_sel` in 8: source 0 message word.
- `data_shoot_control` in 8: source 1 message word.
- `data_mouse_control` in 8: source 2 message word.
- `data_score_control` in 8: source 3 message word.
- `tx_full` in 1: UART TX FIFO full.
- `w_data` out 8: byte to UART TX FIFO.
- `wr_uart` out 1: one-cycle write strobe.
- `grant_id` out 2: source index of the current or last write.

## Operation
- Per-source state: `last_sent[i]` (8b) and `pending[i]` (1b).
- Change detect, registered:
  - `pending[i]` is set when `data_i != last_sent[i]` and `data_i != 8'h00`.
  - `data_i == 8'h00` is the idle word and is never transmitted. On it, `last_sent[i] <= 8'h00` and `pending[i]` clears.
- FSM states and transitions:
  - IDLE -> SEND when `|pending` and `!tx_full`.
    - Winner = first pending index at or after `rr_ptr`, wrapping 3 -> 0.
    - Registers `w_data <= data_winner`, sampled live rather than queued, so the latest value wins.
    - Sets `grant_id <= winner`, `wr_uart <= 1`.
  - SEND (1 cycle) -> GAP.
    - `wr_uart` high for exactly this cycle.
    - `last_sent[winner] <= w_data`; `pending[winner]` clears.
    - `rr_ptr <= winner+1` (mod 4).
  - GAP: counts `GAP_CYCLES` cycles with `wr_uart` low, then -> IDLE.
- Simultaneous events:
  - A source changing again during its own SEND re-sets `pending` on the next cycle, because the compare uses the new `last_sent`.
  - Change detect on the other sources continues in all states.
- `tx_full`:
  - Sampled only in IDLE. While high, no grant; pending flags hold, and there is no drop and no timeout.
  - A rise during SEND does not cancel the strobe. `GAP_CYCLES` ≥ 1 guarantees `tx_full` is re-checked before the next write.
- Reset (async, at any point including mid-SEND):
  - Outputs: `w_data = 8'h00`, `wr_uart = 0`, `grant_id = 2'd0`.
  - Internal: `last_sent` all 0, `pending` all 0, `rr_ptr = 0`, FSM = IDLE, gap/refresh counters 0.
  - An in-flight strobe is cut immediately.

## Timing
- Input word change at edge k:
  - `pending` is set at k+1.
  - `wr_uart` is high in cycle k+2 (FSM idle, `tx_full` low).
- Back-to-back writes are spaced by at least `GAP_CYCLES`+2 cycles: the SEND cycle, then `GAP_CYCLES` cycles of GAP, then one IDLE decision cycle.
- Starvation bound: a pending source is granted within 4 write slots after `tx_full` stays low.
- `w_data` is stable from the `wr_uart` cycle until the next grant.

## Configuration
- Macro `UART_ARB_REFRESH_EN`.
- Defined:
  - A free-running counter wraps every `REFRESH_CYCLES`.
  - On wrap, `pending[i]` is set for every i with `last_sent[i] != 8'h00`, which resends live state so the peer board recovers lost bytes.
  - A refresh tick coinciding with a change-detect is one pending flag; there are no duplicates.
- Undefined: no counter logic; sends are change-triggered only.

## Test plan
- Reset, all sources at 8'h00, run 1000 cycles -> `wr_uart` never asserted, `w_data` = 8'h00, `grant_id` = 0.
- Source 2 set to 8'h35 at edge k -> `wr_uart` = 1 exactly in cycle k+2, `w_data` = 8'h35, `grant_id` = 2, single pulse, no repeat.
- All four sources set together to 8'h11, 8'h22, 8'h33, 8'h44, `GAP_CYCLES` = 4 -> writes in order 0,1,2,3, each spaced 6 cycles; then source 0 changes to 8'h19 -> next write is 8'h19.
- `tx_full` held high while source 3 changes to 8'h0C for 50 cycles -> no strobe. Drop `tx_full` -> 8'h0C written 1 cycle later; source 3 changing to 8'h0D while blocked -> only 8'h0D is written.
- Assert `rst` during the SEND cycle -> `wr_uart` falls asynchronously, and after release no write occurs until an input changes.
- With `UART_ARB_REFRESH_EN`, `REFRESH_CYCLES` = 200, source 1 at 8'h2A already sent -> 8'h2A rewritten every 200 cycles (±gap jitter); source 0 at 8'h00 never sent.
